// File: rtl/pixel_block_packer.sv
// Packs a byte stream into 128-bit AES plaintext blocks, pads a short final
// block with PAD_BYTE and handshakes each block with the AES core.
module pixel_block_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   pix_data,
  input  logic         pix_valid,
  input  logic         pix_last,
  output logic         pix_ready,
  output logic [127:0] aes_block,
  output logic         aes_start,
  input  logic         aes_done,
  output logic         blk_last,
  output logic [4:0]   pad_len,
  output logic [15:0]  blk_count
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t         state_r;
  logic [3:0]     idx_r;
  logic           pix_ready_r;
  logic [127:0]   aes_block_r;
  logic           aes_start_r;
  logic           blk_last_r;
  logic [4:0]     pad_len_r;
  logic [15:0]    blk_count_r;
  logic           xfer_s;

  // Overwrite every byte position at or beyond cnt (bytes received) with pad.
  function automatic logic [127:0] pad_fill(input logic [127:0] blk,
                                            input logic [3:0]   cnt,
                                            input logic [7:0]   pad);
    logic [127:0] res;
    logic [6:0]   pos;
    res = blk;
    for (int i = 0; i < 16; i++) begin
      pos = 7'd127 - {i[3:0], 3'b000};
      if (i[3:0] >= cnt) begin
        res[pos -: 8] = pad;
      end else begin
        res[pos -: 8] = blk[pos -: 8];
      end
    end
    return res;
  endfunction

  assign xfer_s = pix_valid & pix_ready_r;

  // Packer state machine; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= FILL;
      idx_r       <= 4'd0;
      pix_ready_r <= 1'b1;
      aes_block_r <= 128'd0;
      aes_start_r <= 1'b0;
      blk_last_r  <= 1'b0;
      pad_len_r   <= 5'd0;
      blk_count_r <= 16'd0;
    end else begin
      aes_start_r <= 1'b0;
      case (state_r)
        FILL: begin
          if (xfer_s) begin
            aes_block_r[7'd127 - {idx_r, 3'b000} -: 8] <= pix_data;
            idx_r      <= idx_r + 4'd1;
            blk_last_r <= pix_last;
            if (idx_r == 4'd15) begin
              state_r     <= ISSUE;
              aes_start_r <= 1'b1;
              pad_len_r   <= 5'd0;
              pix_ready_r <= 1'b0;
            end else if (pix_last) begin
              state_r     <= PAD;
              pad_len_r   <= {1'b0, 4'd15 - idx_r};
              pix_ready_r <= 1'b0;
            end else begin
              state_r <= FILL;
            end
          end
        end
        PAD: begin
          // idx_r already holds the count of bytes received for this block
          aes_block_r <= pad_fill(aes_block_r, idx_r, PAD_BYTE);
          aes_start_r <= 1'b1;
          state_r     <= ISSUE;
        end
        ISSUE: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (aes_done) begin
            blk_count_r <= blk_count_r + 16'd1;
            idx_r       <= 4'd0;
            aes_block_r <= 128'd0;
            blk_last_r  <= 1'b0;
            pad_len_r   <= 5'd0;
            pix_ready_r <= 1'b1;
            state_r     <= FILL;
          end
        end
        default: begin
          state_r     <= FILL;
          idx_r       <= 4'd0;
          pix_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign pix_ready = pix_ready_r;
  assign aes_block = aes_block_r;
  assign aes_start = aes_start_r;
  assign blk_last  = blk_last_r;
  assign pad_len   = pad_len_r;
  assign blk_count = blk_count_r;

endmodule

// File: tb/tb_pixel_block_packer.sv
// Directed self-checking bench for pixel_block_packer.
module tb_pixel_block_packer;

  logic         clk;
  logic         rst;
  logic [7:0]   pix_data;
  logic         pix_valid;
  logic         pix_last;
  logic         pix_ready;
  logic [127:0] aes_block;
  logic         aes_start;
  logic         aes_done;
  logic         blk_last;
  logic [4:0]   pad_len;
  logic [15:0]  blk_count;

  int n_checks = 0;
  int n_errors = 0;

  pixel_block_packer #(.PAD_BYTE(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_last  (pix_last),
    .pix_ready (pix_ready),
    .aes_block (aes_block),
    .aes_start (aes_start),
    .aes_done  (aes_done),
    .blk_last  (blk_last),
    .pad_len   (pad_len),
    .blk_count (blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    check_value("ready_before_xfer", {127'd0, pix_ready}, 128'd1);
    step();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic done_pulse();
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    pix_data  = 8'h00;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    aes_done  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check_value("rst_ready", {127'd0, pix_ready}, 128'd1);
    check_value("rst_start", {127'd0, aes_start}, 128'd0);
    check_value("rst_block", aes_block, 128'd0);
    check_value("rst_count", {112'd0, blk_count}, 128'd0);
    check_value("rst_padlen", {123'd0, pad_len}, 128'd0);
    check_value("rst_last", {127'd0, blk_last}, 128'd0);

    // Full 16-byte block, pix_last on the 16th byte
    for (int k = 0; k < 16; k++) begin
      send_byte(8'(k * 17), (k == 15));
    end
    check_value("full_start_n1", {127'd0, aes_start}, 128'd1);
    check_value("full_block", aes_block, 128'h00112233445566778899aabbccddeeff);
    check_value("full_padlen", {123'd0, pad_len}, 128'd0);
    check_value("full_last", {127'd0, blk_last}, 128'd1);
    check_value("full_ready_issue", {127'd0, pix_ready}, 128'd0);
    step();
    check_value("full_start_wait", {127'd0, aes_start}, 128'd0);
    done_pulse();
    check_value("full_count", {112'd0, blk_count}, 128'd1);
    check_value("full_ready_after", {127'd0, pix_ready}, 128'd1);
    check_value("full_block_clr", aes_block, 128'd0);
    check_value("full_last_clr", {127'd0, blk_last}, 128'd0);

    // Short block AA BB CC: one PAD cycle, start at N+2
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    send_byte(8'hcc, 1'b1);
    check_value("short_pad_nostart", {127'd0, aes_start}, 128'd0);
    check_value("short_pad_ready", {127'd0, pix_ready}, 128'd0);
    check_value("short_padlen", {123'd0, pad_len}, 128'd13);
    check_value("short_last", {127'd0, blk_last}, 128'd1);
    step();
    check_value("short_start_n2", {127'd0, aes_start}, 128'd1);
    check_value("short_block", aes_block, {24'haabbcc, 104'd0});
    step();
    check_value("short_start_off", {127'd0, aes_start}, 128'd0);

    // 5A held during WAIT must not be consumed until FILL
    pix_valid = 1'b1;
    pix_data  = 8'h5a;
    repeat (3) step();
    check_value("hold_ready_wait", {127'd0, pix_ready}, 128'd0);
    check_value("hold_block_stable", aes_block, {24'haabbcc, 104'd0});
    check_value("hold_padlen_stable", {123'd0, pad_len}, 128'd13);
    done_pulse();
    check_value("hold_ready_fill", {127'd0, pix_ready}, 128'd1);
    check_value("hold_count", {112'd0, blk_count}, 128'd2);
    check_value("hold_block_clr", aes_block, 128'd0);
    step();
    pix_valid = 1'b0;
    check_value("hold_5a_msb", aes_block, {8'h5a, 120'd0});

    // aes_done during ISSUE is ignored
    send_byte(8'h77, 1'b1);
    step();
    check_value("issue_start", {127'd0, aes_start}, 128'd1);
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
    check_value("issue_done_ignored_ready", {127'd0, pix_ready}, 128'd0);
    check_value("issue_done_ignored_cnt", {112'd0, blk_count}, 128'd2);
    check_value("issue_block", aes_block, {16'h5a77, 112'd0});
    check_value("issue_padlen", {123'd0, pad_len}, 128'd14);
    repeat (2) step();
    check_value("issue_still_wait", {127'd0, pix_ready}, 128'd0);
    done_pulse();
    check_value("issue_later_done", {112'd0, blk_count}, 128'd3);
    check_value("issue_back_fill", {127'd0, pix_ready}, 128'd1);

    // Reset mid-WAIT, then a stale aes_done after release
    send_byte(8'hc3, 1'b1);
    repeat (2) step();
    check_value("rw_ready_wait", {127'd0, pix_ready}, 128'd0);
    #2 rst = 1'b0;
    #1;
    check_value("rw_async_block", aes_block, 128'd0);
    check_value("rw_async_count", {112'd0, blk_count}, 128'd0);
    check_value("rw_async_last", {127'd0, blk_last}, 128'd0);
    check_value("rw_async_padlen", {123'd0, pad_len}, 128'd0);
    check_value("rw_async_start", {127'd0, aes_start}, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    done_pulse();
    check_value("rw_stale_count", {112'd0, blk_count}, 128'd0);
    check_value("rw_stale_ready", {127'd0, pix_ready}, 128'd1);
    check_value("rw_stale_block", aes_block, 128'd0);
    send_byte(8'he1, 1'b0);
    check_value("rw_first_byte", aes_block, {8'he1, 120'd0});

    // blk_count wrap from FFFF
    force dut.blk_count_r = 16'hffff;
    step();
    release dut.blk_count_r;
    step();
    check_value("wrap_preload", {112'd0, blk_count}, 128'h0000ffff);
    send_byte(8'h0f, 1'b1);
    repeat (2) step();
    check_value("wrap_block", aes_block, {16'he10f, 112'd0});
    done_pulse();
    check_value("wrap_count", {112'd0, blk_count}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_block_packer.md
PIXEL_BLOCK_PACKER -- requirements
Module: pixel_block_packer

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'h00: the byte value used to fill unused positions of a short final block.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have port pix_data, input, 8 bits: pixel byte from the image source.
REQ-005 SHALL have port pix_valid, input, 1 bit: pix_data is valid this cycle.
REQ-006 SHALL have port pix_last, input, 1 bit: qualifies pix_data as the final byte of the image; sampled only on a transfer.
REQ-007 SHALL have port pix_ready, output, 1 bit: the packer accepts a byte this cycle; transfer = pix_valid & pix_ready.
REQ-008 SHALL have port aes_block, output, 128 bits: assembled block driving the AES plaintext input.
REQ-009 SHALL have port aes_start, output, 1 bit: single-cycle request to the AES core.
REQ-010 SHALL have port aes_done, input, 1 bit: AES core completion for the issued block.
REQ-011 SHALL have port blk_last, output, 1 bit: aes_block is the final block of the image.
REQ-012 SHALL have port pad_len, output, 5 bits: number of padded bytes in aes_block (0..15).
REQ-013 SHALL have port blk_count, output, 16 bits: number of blocks completed (aes_done seen) since reset.

Function
REQ-014 SHALL implement states FILL, PAD, ISSUE, WAIT; FILL on reset.
REQ-015 SHALL drive pix_ready=1 only in FILL; 0 in PAD, ISSUE, WAIT.
REQ-016 SHALL keep a 4-bit byte index idx, 0 on entry to FILL, incremented by 1 per transfer.
REQ-017 SHALL place the byte of a transfer at aes_block[127-8*idx -: 8] (first byte in MSB, i.e. bits [127:120]).
REQ-018 SHALL, on a transfer with idx=15 (with or without pix_last), go FILL->ISSUE next cycle with pad_len=0.
REQ-019 SHALL, on a transfer with pix_last=1 and idx<15, go FILL->PAD next cycle and set pad_len=15-idx.
REQ-020 SHALL, in PAD (exactly one cycle), fill all byte positions after the last received byte with PAD_BYTE, then go to ISSUE.
REQ-021 SHALL set blk_last=1 when the block was terminated by pix_last; 0 otherwise; held until next block starts filling.
REQ-022 SHALL assert aes_start for exactly the one cycle spent in ISSUE, then go to WAIT.
REQ-023 SHALL hold aes_block, blk_last and pad_len stable from ISSUE until the cycle after aes_done is seen in WAIT.
REQ-024 SHALL sample aes_done only in WAIT; aes_done in any other state SHALL be ignored.
REQ-025 SHALL, on aes_done in WAIT, increment blk_count (modulo 2^16, 16'hFFFF wraps to 0), clear idx, return to FILL.
REQ-026 SHALL, on re-entering FILL, clear aes_block to 0, blk_last to 0, pad_len to 0.
REQ-027 SHALL give latency: 16th-byte transfer in cycle N -> aes_start high in cycle N+1; short-block last transfer in cycle N -> aes_start in cycle N+2.
REQ-028 SHALL never lose or duplicate a byte: pix_valid held during PAD/ISSUE/WAIT is not consumed; pix_data may change freely while pix_ready=0.

Reset
REQ-029 SHALL, while rst=0, immediately force state FILL, idx=0, aes_block=0, aes_start=0, blk_last=0, pad_len=0, blk_count=0; pix_ready=1 after rst deasserts.
REQ-030 SHALL, on rst asserted in any state (including WAIT with a block outstanding), abandon the partial/outstanding block; an aes_done arriving after reset release in FILL SHALL be ignored.

Verification
REQ-031 SHALL pass: 16 bytes 00,11,22,...,FF back-to-back, pix_last on last -> aes_block=00112233445566778899aabbccddeeff, aes_start one cycle after 16th transfer, pad_len=0, blk_last=1.
REQ-032 SHALL pass: bytes AA,BB,CC with pix_last on CC -> PAD one cycle, aes_block=AABBCC followed by 13 bytes 00, pad_len=13, blk_last=1, aes_start at N+2.
REQ-033 SHALL pass: pix_valid held high during WAIT with data 5A -> pix_ready=0, byte not consumed until aes_done returns FILL, then 5A lands at bits [127:120].
REQ-034 SHALL pass: rst pulled low mid-WAIT, then aes_done pulsed after release -> all outputs 0, blk_count stays 0, no state change.
REQ-035 SHALL pass: preload 65535 completed blocks (or force), complete one more -> blk_count wraps to 0.
REQ-036 SHALL pass: aes_done asserted during ISSUE cycle -> ignored; packer remains in WAIT until a later aes_done.
